sdram_port_arbiter: RTL and testbench

Parametrised N-client arbiter for one SDRAM channel. It generalises the fixed "ROM-download writer overrides one graphics reader" channel mux in the core top-level to NCH read clients. Read clients are served round-robin, each through a one-deep request latch. A download write port has absolute priority while `dl_active` is high. The block sits between the core's graphics/CPU fetch units plus the ROM loader and a single `sdram` controller channel, in the SDRAM clock domain.

---
 rtl/sdram_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin N-client SDRAM channel arbiter with download write priority
module sdram_port_arbiter #(
  parameter int NCH = 4,
  parameter int AW  = 24,
  parameter int DW  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              dl_req,
  input  logic [AW-1:0]     dl_addr,
  input  logic [DW-1:0]     dl_data,
  input  logic [1:0]        dl_be,
  output logic              dl_ack,
  input  logic [NCH-1:0]    cli_req,
  input  logic [NCH*AW-1:0] cli_addr,
  output logic [NCH*DW-1:0] cli_dout,
  output logic [NCH-1:0]    cli_rdy,
  output logic              mem_req,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_din,
  output logic [1:0]        mem_be,
  output logic              mem_rnw,
  input  logic [DW-1:0]     mem_dout,
  input  logic              mem_rdy
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]     state;
  logic [NCH-1:0] pend;
  logic [AW-1:0]  paddr [NCH];
  logic           dpend;
  logic [AW-1:0]  daddr;
  logic [DW-1:0]  ddata;
  logic [1:0]     dbe;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  gnt_idx;
  logic           gnt_dl;
  logic           sel_found;
  logic [PW-1:0]  sel_idx;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int ofs);
    int s;
    s = 32'(base) + ofs;
    if (s >= NCH) s = s - NCH;
    return s[PW-1:0];
  endfunction

  // Descending scan so the last hit is the client closest to ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (pend[wrap_add(ptr, k)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_add(ptr, k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      pend     <= '0;
      dpend    <= 1'b0;
      daddr    <= '0;
      ddata    <= '0;
      dbe      <= '0;
      ptr      <= '0;
      gnt_idx  <= '0;
      gnt_dl   <= 1'b0;
      for (int i = 0; i < NCH; i++) paddr[i] <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_be   <= '0;
      mem_rnw  <= 1'b1;
      cli_dout <= '0;
      cli_rdy  <= '0;
      dl_ack   <= 1'b0;
    end else begin
      mem_req <= 1'b0;
      cli_rdy <= '0;
      dl_ack  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dpend) begin
            dpend    <= 1'b0;
            gnt_dl   <= 1'b1;
            mem_addr <= daddr;
            mem_din  <= ddata;
            mem_be   <= dbe;
            mem_rnw  <= 1'b0;
            mem_req  <= 1'b1;
            state    <= S_ISSUE;
          end else if (!dl_active && sel_found) begin
            pend[sel_idx] <= 1'b0;
            gnt_dl   <= 1'b0;
            gnt_idx  <= sel_idx;
            mem_addr <= paddr[sel_idx];
            mem_be   <= 2'b11;
            mem_rnw  <= 1'b1;
            mem_req  <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (mem_rdy) begin
            if (gnt_dl) begin
              dl_ack <= 1'b1;
            end else begin
              cli_dout[32'(gnt_idx)*DW +: DW] <= mem_dout;
              cli_rdy[gnt_idx] <= 1'b1;
              ptr <= wrap_add(gnt_idx, 1);
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // New requests are latched after the grant so a same-cycle re-request survives the clear.
      for (int i = 0; i < NCH; i++) begin
        if (cli_req[i]) begin
          pend[i]  <= 1'b1;
          paddr[i] <= cli_addr[i*AW +: AW];
        end
      end
      if (dl_req && dl_active) begin
        dpend <= 1'b1;
        daddr <= dl_addr;
        ddata <= dl_data;
        dbe   <= dl_be;
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - randomized and directed bench for sdram_port_arbiter
module tb_sdram_port_arbiter;
  localparam int NCH = 4;
  localparam int AW  = 24;
  localparam int DW  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              dl_active, dl_req;
  logic [AW-1:0]     dl_addr;
  logic [DW-1:0]     dl_data;
  logic [1:0]        dl_be;
  logic              dl_ack;
  logic [NCH-1:0]    cli_req;
  logic [NCH*AW-1:0] cli_addr;
  logic [NCH*DW-1:0] cli_dout;
  logic [NCH-1:0]    cli_rdy;
  logic              mem_req;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_din;
  logic [1:0]        mem_be;
  logic              mem_rnw;
  logic [DW-1:0]     mem_dout;
  logic              mem_rdy;

  sdram_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .dl_active(dl_active), .dl_req(dl_req), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_be(dl_be), .dl_ack(dl_ack),
    .cli_req(cli_req), .cli_addr(cli_addr), .cli_dout(cli_dout), .cli_rdy(cli_rdy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be),
    .mem_rnw(mem_rnw), .mem_dout(mem_dout), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit cmp_en = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Controller: answers each mem_req after 'lat' cycles; may emit stray completions when idle.
  int            lat = 3;
  int            rcnt = 0;
  bit            stray_en = 0;
  bit            force_en = 0;
  logic [DW-1:0] force_data = '0;
  logic [DW-1:0] rdata;

  always @(posedge clk) begin
    #1;
    mem_rdy = 1'b0;
    if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        mem_rdy  = 1'b1;
        mem_dout = rdata;
      end
    end else if (stray_en && !mem_req && $urandom_range(0, 11) == 0) begin
      mem_rdy  = 1'b1;
      mem_dout = 16'($urandom);
    end
    if (mem_req) begin
      rcnt  = lat;
      rdata = force_en ? force_data : (mem_addr[15:0] ^ 16'hC3A5);
    end
  end

  // Reference model: latched requests, one transaction in flight, round-robin pointer.
  logic           m_pend [NCH];
  logic [AW-1:0]  m_paddr [NCH];
  bit             m_dpend, m_busy, m_fresh, m_isdl, m_rst;
  logic [AW-1:0]  m_daddr;
  logic [DW-1:0]  m_ddata;
  logic [1:0]     m_dbe;
  int             m_ptr, m_who, pick;
  logic           e_mem_req, e_dl_ack, e_rnw;
  logic [NCH-1:0] e_cli_rdy;
  logic [AW-1:0]  e_addr;
  logic [DW-1:0]  e_din;
  logic [1:0]     e_be;
  logic [NCH*DW-1:0] e_dout;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_pend[i] = 0;
        m_paddr[i] = '0;
      end
      m_dpend = 0; m_busy = 0; m_fresh = 0; m_isdl = 0; m_ptr = 0; m_who = 0; m_rst = 1;
      e_mem_req = 0; e_dl_ack = 0; e_cli_rdy = '0; e_rnw = 1;
      e_addr = '0; e_din = '0; e_be = '0; e_dout = '0;
    end else begin
      m_rst = 0;
      e_mem_req = 0; e_dl_ack = 0; e_cli_rdy = '0;
      if (m_busy) begin
        if (m_fresh) m_fresh = 0;
        else if (mem_rdy) begin
          m_busy = 0;
          if (m_isdl) e_dl_ack = 1;
          else begin
            e_cli_rdy[m_who] = 1'b1;
            e_dout[m_who*DW +: DW] = mem_dout;
            m_ptr = (m_who + 1) % NCH;
          end
        end
      end else if (m_dpend) begin
        m_dpend = 0;
        e_addr = m_daddr; e_din = m_ddata; e_be = m_dbe; e_rnw = 0;
        e_mem_req = 1; m_busy = 1; m_fresh = 1; m_isdl = 1;
      end else if (!dl_active) begin
        pick = -1;
        for (int k = 0; k < NCH; k++)
          if (pick < 0 && m_pend[(m_ptr + k) % NCH]) pick = (m_ptr + k) % NCH;
        if (pick >= 0) begin
          m_pend[pick] = 0;
          e_addr = m_paddr[pick]; e_rnw = 1;
          e_mem_req = 1; m_busy = 1; m_fresh = 1; m_isdl = 0; m_who = pick;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (cli_req[i]) begin
          m_pend[i] = 1;
          m_paddr[i] = cli_addr[i*AW +: AW];
        end
      end
      if (dl_req && dl_active) begin
        m_dpend = 1; m_daddr = dl_addr; m_ddata = dl_data; m_dbe = dl_be;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mem_req", 64'(mem_req), 64'(e_mem_req));
      chk("cli_rdy", 64'(cli_rdy), 64'(e_cli_rdy));
      chk("dl_ack", 64'(dl_ack), 64'(e_dl_ack));
      chk("cli_dout", 64'(cli_dout), 64'(e_dout));
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      chk("mem_rnw", 64'(mem_rnw), 64'(e_rnw));
      if (!e_rnw || m_rst) begin
        chk("mem_din", 64'(mem_din), 64'(e_din));
        chk("mem_be", 64'(mem_be), 64'(e_be));
      end
    end
  end

  // Event logs for the directed literal checks.
  typedef struct { int cyc; logic [AW-1:0] addr; logic rnw; logic [DW-1:0] din; logic [1:0] be; } req_t;
  typedef struct { int cyc; int idx; logic [DW-1:0] data; } rdy_t;
  req_t rq_log[$];
  rdy_t rdy_log[$];
  int   dl_acks = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      if (mem_req) rq_log.push_back('{cyc, mem_addr, mem_rnw, mem_din, mem_be});
      for (int i = 0; i < NCH; i++)
        if (cli_rdy[i]) rdy_log.push_back('{cyc, i, cli_dout[i*DW +: DW]});
      if (dl_ack) dl_acks++;
    end
  end

  task automatic clear_logs();
    rq_log.delete();
    rdy_log.delete();
    dl_acks = 0;
  endtask

  int t0;

  initial begin
    reset = 1; dl_active = 0; dl_req = 0; dl_addr = '0; dl_data = '0; dl_be = '0;
    cli_req = '0; cli_addr = '0; mem_dout = '0; mem_rdy = 0;
    tick(1);
    cmp_en = 1;
    tick(2);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_rnw", 64'(mem_rnw), 64'd1);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_cli_dout", 64'(cli_dout), 64'd0);
    reset = 0;
    tick(2);

    // Single read, client 2, controller latency 5.
    clear_logs();
    lat = 5; force_en = 1; force_data = 16'hBEEF;
    cli_addr[2*AW +: AW] = 24'h001234; cli_req = 4'b0100; t0 = cyc;
    tick(1); cli_req = '0;
    tick(15);
    chk("t1_nreq", 64'(rq_log.size()), 64'd1);
    if (rq_log.size() == 1) begin
      chk("t1_req_cyc", 64'(rq_log[0].cyc), 64'(t0 + 2));
      chk("t1_addr", 64'(rq_log[0].addr), 64'h1234);
      chk("t1_rnw", 64'(rq_log[0].rnw), 64'd1);
    end
    chk("t1_nrdy", 64'(rdy_log.size()), 64'd1);
    if (rdy_log.size() == 1) begin
      chk("t1_rdy_idx", 64'(rdy_log[0].idx), 64'd2);
      chk("t1_rdy_cyc", 64'(rdy_log[0].cyc), 64'(t0 + 8));
      chk("t1_rdy_data", 64'(rdy_log[0].data), 64'hBEEF);
    end
    chk("t1_dout_held", 64'(cli_dout[2*DW +: DW]), 64'hBEEF);
    force_en = 0;

    // All four clients at once, twice, latency 3, from a fresh pointer.
    reset = 1; tick(1); reset = 0; tick(1);
    clear_logs();
    lat = 3;
    for (int i = 0; i < NCH; i++) cli_addr[i*AW +: AW] = 24'(24'h000100 + i);
    for (int b = 0; b < 2; b++) begin
      cli_req = 4'b1111; tick(1); cli_req = '0;
      tick(40);
    end
    chk("t2_nrdy", 64'(rdy_log.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < rdy_log.size()) begin
        chk("t2_order", 64'(rdy_log[k].idx), 64'(k % 4));
        chk("t2_data", 64'(rdy_log[k].data), 64'((16'h0100 + 16'(k % 4)) ^ 16'hC3A5));
      end
    end

    // Download write overrides a pending client while dl_active is high.
    clear_logs();
    dl_active = 1;
    cli_addr[1*AW +: AW] = 24'h000200; cli_req = 4'b0010;
    tick(1); cli_req = '0;
    dl_req = 1; dl_addr = 24'h000010; dl_data = 16'hA55A; dl_be = 2'b01;
    tick(1); dl_req = 0;
    tick(20);
    chk("t3_nreq_dl", 64'(rq_log.size()), 64'd1);
    if (rq_log.size() >= 1) begin
      chk("t3_rnw", 64'(rq_log[0].rnw), 64'd0);
      chk("t3_addr", 64'(rq_log[0].addr), 64'h10);
      chk("t3_din", 64'(rq_log[0].din), 64'hA55A);
      chk("t3_be", 64'(rq_log[0].be), 64'd1);
    end
    chk("t3_dl_ack", 64'(dl_acks), 64'd1);
    chk("t3_no_cli", 64'(rdy_log.size()), 64'd0);
    dl_active = 0;
    tick(20);
    chk("t3_nreq_all", 64'(rq_log.size()), 64'd2);
    if (rq_log.size() == 2) begin
      chk("t3_cli_addr", 64'(rq_log[1].addr), 64'h200);
      chk("t3_cli_rnw", 64'(rq_log[1].rnw), 64'd1);
    end
    chk("t3_nrdy", 64'(rdy_log.size()), 64'd1);
    if (rdy_log.size() == 1) chk("t3_rdy_idx", 64'(rdy_log[0].idx), 64'd1);

    // Repeat request before grant: only the last address is read.
    clear_logs();
    lat = 8;
    cli_addr[1*AW +: AW] = 24'h000300; cli_req = 4'b0010;
    tick(1); cli_req = '0;
    tick(3);
    cli_addr[0 +: AW] = 24'h000040; cli_req = 4'b0001;
    tick(1);
    cli_addr[0 +: AW] = 24'h000080;
    tick(1); cli_req = '0;
    tick(30);
    chk("t4_nreq", 64'(rq_log.size()), 64'd2);
    if (rq_log.size() == 2) chk("t4_addr", 64'(rq_log[1].addr), 64'h80);
    chk("t4_nrdy", 64'(rdy_log.size()), 64'd2);
    if (rdy_log.size() == 2) begin
      chk("t4_rdy_idx", 64'(rdy_log[1].idx), 64'd0);
      chk("t4_rdy_data", 64'(rdy_log[1].data), 64'(16'h0080 ^ 16'hC3A5));
    end

    // Reset while waiting; the stale completion must be ignored.
    clear_logs();
    lat = 6;
    cli_addr[3*AW +: AW] = 24'h000500; cli_req = 4'b1000;
    tick(1); cli_req = '0;
    tick(4);
    reset = 1; tick(1);
    chk("t5_mem_req", 64'(mem_req), 64'd0);
    chk("t5_mem_addr", 64'(mem_addr), 64'd0);
    chk("t5_mem_rnw", 64'(mem_rnw), 64'd1);
    chk("t5_cli_dout", 64'(cli_dout), 64'd0);
    reset = 0;
    tick(10);
    chk("t5_no_rdy", 64'(rdy_log.size()), 64'd0);
    chk("t5_no_ack", 64'(dl_acks), 64'd0);
    clear_logs();
    lat = 3;
    cli_addr[0 +: AW] = 24'h000600; cli_addr[3*AW +: AW] = 24'h000700; cli_req = 4'b1001;
    tick(1); cli_req = '0;
    tick(30);
    chk("t5_nrdy", 64'(rdy_log.size()), 64'd2);
    if (rdy_log.size() == 2) begin
      chk("t5_first", 64'(rdy_log[0].idx), 64'd0);
      chk("t5_second", 64'(rdy_log[1].idx), 64'd3);
    end

    // Download request without dl_active is dropped.
    clear_logs();
    dl_active = 0; dl_req = 1; dl_addr = 24'h000020; dl_data = 16'h1111; dl_be = 2'b11;
    tick(1); dl_req = 0;
    tick(10);
    chk("t6_nreq", 64'(rq_log.size()), 64'd0);
    chk("t6_ack", 64'(dl_acks), 64'd0);

    // Randomized traffic against the reference model.
    stray_en = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NCH; i++) begin
        cli_req[i] = ($urandom_range(0, 7) == 0);
        cli_addr[i*AW +: AW] = 24'($urandom);
      end
      if ($urandom_range(0, 59) == 0) dl_active = ~dl_active;
      dl_req  = ($urandom_range(0, 5) == 0);
      dl_addr = 24'($urandom);
      dl_data = 16'($urandom);
      dl_be   = 2'($urandom);
      lat     = $urandom_range(1, 4);
      reset   = ($urandom_range(0, 699) == 0);
      tick(1);
    end
    cli_req = '0; dl_req = 0; dl_active = 0; reset = 0; stray_en = 0;
    tick(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
